if_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/if_id_reg.sv | 39 +++
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, widths and reset constants.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: load, squash, hold and valid tracking.
import cpu_pkg::*;

module if_id_reg #(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            squash,
    input  logic            id_ready,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= XLEN'(NOP_INSTR);
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_d;
            pc       <= pc_d;
            pc_plus4 <= pc_plus4_d;
        end else if (valid && id_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding fetch FSM and IF/ID slot.
import cpu_pkg::*;

module if_stage #(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    if_state_t       state, state_next;
    logic [XLEN-1:0] pc, pc_plus4, redirect_tgt;
    logic            slot_free, issue, load;

    assign pc_plus4     = pc + XLEN'(PC_INCR);
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign slot_free    = !if_valid || id_ready;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!redirect_valid && slot_free) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rvalid ? S_IDLE : S_DISCARD;
                end else if (imem_rvalid) begin
                    load       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            // a response here always retires the wrong-path fetch, even under redirect
            S_DISCARD: begin
                if (imem_rvalid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (rst) begin
            issue = 1'b0;
            load  = 1'b0;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = issue ? pc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid) pc <= redirect_tgt;
            else if (load)      pc <= pc_plus4;
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .squash     (redirect_valid),
        .id_ready   (id_ready),
        .instr_d    (imem_rdata),
        .pc_d       (pc),
        .pc_plus4_d (pc_plus4),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4)
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    if_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (32'hCAFE_0001),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .id_ready       (1'b1),
        .if_valid       (w_valid),
        .if_instr       (w_instr),
        .if_pc          (w_pc),
        .if_pc_plus4    (w_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // latency-1 memory for the wrap instance
    always @(posedge clk) w_rvalid <= w_req;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int lat  = 1;

    int          q_due[$];
    logic [31:0] q_addr[$];

    bit          redir_on_rv = 0;
    logic [31:0] redir_on_rv_pc;
    bit          wrap_on = 0;
    int          wrap_c0;

    bit          m_out, m_wrong, m_valid;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C82_0004;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic step(input bit r, input bit rdy, input bit rdir,
                        input logic [31:0] rpc);
        bit          rv, exp_req;
        logic [31:0] rd;
        @(negedge clk);
        rv = 0;
        rd = $urandom;
        for (int i = 0; i < q_due.size(); i++) begin
            if (q_due[i] == cyc) begin
                rv = 1;
                rd = mem_word(q_addr[i]);
                q_due.delete(i);
                q_addr.delete(i);
                break;
            end
        end
        if (redir_on_rv && rv && m_out && !r) begin
            rdir        = 1;
            rpc         = redir_on_rv_pc;
            redir_on_rv = 0;
        end
        rst            = r;
        id_ready       = rdy;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        #1;
        exp_req = !r && !m_out && !rdir && (!m_valid || rdy);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, exp_req ? m_pc : 32'h0);
        if (wrap_on && cyc == wrap_c0) begin
            chk("wrap_req0", 32'(w_req), 32'h1);
            chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        end
        if (wrap_on && cyc == wrap_c0 + 2) begin
            chk("wrap_req1", 32'(w_req), 32'h1);
            chk("wrap_addr1", w_addr, 32'h0);
        end
        if (imem_req) begin
            q_due.push_back(cyc + lat);
            q_addr.push_back(imem_addr);
        end
        if (r) begin
            m_pc = 32'h0; m_out = 0; m_wrong = 0; m_valid = 0;
            m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (m_out && rv) begin
                if (!m_wrong && !rdir) begin
                    m_valid = 1;
                    m_instr = rd;
                    m_ipc   = m_pc;
                    m_ipc4  = m_pc + 32'd4;
                    m_pc    = m_pc + 32'd4;
                end
                m_out = 0;
            end
            if (rdir) begin
                m_valid = 0;
                m_pc    = rpc & 32'hFFFF_FFFC;
                if (m_out) m_wrong = 1;
            end
            if (exp_req) begin
                m_out   = 1;
                m_wrong = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("if_instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_ipc);
        chk("if_pc_plus4", if_pc_plus4, m_ipc4);
        if (wrap_on && cyc == wrap_c0 + 1) begin
            chk("wrap_valid", 32'(w_valid), 32'h1);
            chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
            chk("wrap_pc4", w_pc4, 32'h0);
        end
        cyc++;
    endtask

    initial begin
        bit found;
        rst = 1; id_ready = 1; redirect_valid = 0; redirect_pc = 0;
        imem_rvalid = 0; imem_rdata = 0;
        m_pc = 0; m_out = 0; m_wrong = 0; m_valid = 0;
        m_instr = 0; m_ipc = 0; m_ipc4 = 0;

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        wrap_on = 1;
        wrap_c0 = cyc;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        wrap_on = 0;
        chk("held_instr", if_instr, 32'h8C82_0004);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        lat = 3;
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h100);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);

        lat = 2;
        redir_on_rv    = 1;
        redir_on_rv_pc = 32'h203;
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0);
        chk("redir_rv_done", 32'(redir_on_rv), 32'h0);

        lat   = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 1, 0, 0);
            found = m_out && !m_wrong;
        end
        chk("rst_mid_fetch", 32'(found), 32'h1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit          rdir;
            logic [31:0] rpc;
            lat  = $urandom_range(1, 4);
            rdir = ($urandom_range(0, 99) < 8);
            rpc  = ($urandom_range(0, 3) == 0) ?
                   (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 99) == 0) begin
                for (int k = 0; k < 5; k++) step(1, 1, 0, 0);
            end else begin
                step(0, ($urandom_range(0, 99) < 70), rdir, rpc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
